// File: rtl/audio_mix_seq_if.sv
// Bus bundle for the stereo mixer: source-side strobes and packed
// channel data in, mixed sample and status flags out.
interface audio_mix_seq_if #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 24,
    parameter int OUT_W  = 24,
    parameter int GAIN_W = 5
);
    logic                       next_sample;
    logic [NUM_CH*IN_W-1:0]     ch_left;
    logic [NUM_CH*IN_W-1:0]     ch_right;
    logic [NUM_CH*GAIN_W-1:0]   ch_gain;
    logic [NUM_CH-1:0]          ch_mute;
    logic                       overrun_clr;
    logic [OUT_W-1:0]           out_left;
    logic [OUT_W-1:0]           out_right;
    logic                       out_valid;
    logic                       clip_left;
    logic                       clip_right;
    logic                       busy;
    logic                       overrun;

    // Sound-source / controller side.
    modport master (
        output next_sample, ch_left, ch_right, ch_gain, ch_mute, overrun_clr,
        input  out_left, out_right, out_valid, clip_left, clip_right, busy, overrun
    );

    // Mixer side.
    modport slave (
        input  next_sample, ch_left, ch_right, ch_gain, ch_mute, overrun_clr,
        output out_left, out_right, out_valid, clip_left, clip_right, busy, overrun
    );
endinterface

// File: rtl/audio_mix_seq.sv
// Time-multiplexed stereo mixer. On each next_sample strobe the channel
// inputs are snapshotted, one channel per clock is scaled by its Q.4 gain
// and accumulated (left and right in parallel), and the sum is shifted
// down by 4, saturated to OUT_W and presented as one registered sample.
module audio_mix_seq #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 24,
    parameter int OUT_W  = 24,
    parameter int GAIN_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    audio_mix_seq_if.slave    bus
);
    localparam int ACC_W = IN_W + GAIN_W + $clog2(NUM_CH) + 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic signed [CMP_W-1:0] MAX_C =
        {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] MIN_C =
        {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nx_s;

    logic [NUM_CH*IN_W-1:0]   left_r;
    logic [NUM_CH*IN_W-1:0]   right_r;
    logic [NUM_CH*GAIN_W-1:0] gain_r;
    logic [NUM_CH-1:0]        mute_r;
    logic [IDX_W-1:0]         idx_r;
    logic signed [ACC_W-1:0]  acc_left_r;
    logic signed [ACC_W-1:0]  acc_right_r;

    logic [OUT_W-1:0]         out_left_r;
    logic [OUT_W-1:0]         out_right_r;
    logic                     out_valid_r;
    logic                     clip_left_r;
    logic                     clip_right_r;
    logic                     busy_r;
    logic                     overrun_r;

    logic signed [IN_W-1:0]   cur_left_s;
    logic signed [IN_W-1:0]   cur_right_s;
    logic [GAIN_W-1:0]        cur_gain_s;
    logic                     cur_mute_s;
    logic signed [ACC_W-1:0]  gain_ext_s;
    logic signed [ACC_W-1:0]  left_ext_s;
    logic signed [ACC_W-1:0]  right_ext_s;
    logic signed [ACC_W-1:0]  term_left_s;
    logic signed [ACC_W-1:0]  term_right_s;
    logic [OUT_W:0]           sat_left_s;
    logic [OUT_W:0]           sat_right_s;

    // Drop the Q.4 fraction (floor) and clamp to the signed OUT_W range.
    // Result is {clip, sample}.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        logic signed [CMP_W-1:0] wide;
        shifted = acc >>> 3'd4;
        wide    = CMP_W'(shifted);
        if (wide > MAX_C) begin
            saturate = {1'b1, MAX_C[OUT_W-1:0]};
        end else if (wide < MIN_C) begin
            saturate = {1'b1, MIN_C[OUT_W-1:0]};
        end else begin
            saturate = {1'b0, wide[OUT_W-1:0]};
        end
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: IDLE -> ACCUM (NUM_CH cycles) -> SAT -> IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.next_sample) begin
                    state_nx_s = ST_ACCUM;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (idx_r == IDX_LAST) begin
                    state_nx_s = ST_SAT;
                end else begin
                    state_nx_s = ST_ACCUM;
                end
            end
            ST_SAT: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Per-channel scaled contribution for the channel selected by idx.
    // Gain is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        cur_left_s   = left_r[idx_r*IN_W +: IN_W];
        cur_right_s  = right_r[idx_r*IN_W +: IN_W];
        cur_gain_s   = gain_r[idx_r*GAIN_W +: GAIN_W];
        cur_mute_s   = mute_r[idx_r];
        gain_ext_s   = {{(ACC_W-GAIN_W){1'b0}}, cur_gain_s};
        left_ext_s   = ACC_W'(cur_left_s);
        right_ext_s  = ACC_W'(cur_right_s);
        if (cur_mute_s) begin
            term_left_s  = {ACC_W{1'b0}};
            term_right_s = {ACC_W{1'b0}};
        end else begin
            term_left_s  = left_ext_s * gain_ext_s;
            term_right_s = right_ext_s * gain_ext_s;
        end
        sat_left_s  = saturate(acc_left_r);
        sat_right_s = saturate(acc_right_r);
    end

    // Snapshot, accumulate and output registers; a reset mid-mix simply
    // returns everything to zero, so the aborted sample never appears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_r       <= {(NUM_CH*IN_W){1'b0}};
            right_r      <= {(NUM_CH*IN_W){1'b0}};
            gain_r       <= {(NUM_CH*GAIN_W){1'b0}};
            mute_r       <= {NUM_CH{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            acc_left_r   <= {ACC_W{1'b0}};
            acc_right_r  <= {ACC_W{1'b0}};
            out_left_r   <= {OUT_W{1'b0}};
            out_right_r  <= {OUT_W{1'b0}};
            out_valid_r  <= 1'b0;
            clip_left_r  <= 1'b0;
            clip_right_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.next_sample) begin
                        left_r      <= bus.ch_left;
                        right_r     <= bus.ch_right;
                        gain_r      <= bus.ch_gain;
                        mute_r      <= bus.ch_mute;
                        idx_r       <= {IDX_W{1'b0}};
                        acc_left_r  <= {ACC_W{1'b0}};
                        acc_right_r <= {ACC_W{1'b0}};
                        busy_r      <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    acc_left_r  <= acc_left_r + term_left_s;
                    acc_right_r <= acc_right_r + term_right_s;
                    idx_r       <= idx_r + IDX_W'(1);
                end
                ST_SAT: begin
                    out_left_r   <= sat_left_s[OUT_W-1:0];
                    out_right_r  <= sat_right_s[OUT_W-1:0];
                    clip_left_r  <= sat_left_s[OUT_W];
                    clip_right_r <= sat_right_s[OUT_W];
                    out_valid_r  <= 1'b1;
                    busy_r       <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun: a strobe while a mix is in flight; setting beats clearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (bus.next_sample && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.out_left   = out_left_r;
    assign bus.out_right  = out_right_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.clip_left  = clip_left_r;
    assign bus.clip_right = clip_right_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_audio_mix_seq.sv
// Directed bench for audio_mix_seq: expected samples are queued when a
// strobe is driven and compared when out_valid appears.
module tb_audio_mix_seq;
    localparam int NUM_CH = 4;
    localparam int IN_W   = 24;
    localparam int OUT_W  = 24;
    localparam int GAIN_W = 5;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        cl;
        logic        cr;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   sample_id = 0;
    exp_t sb[$];

    logic signed [23:0] m_l [NUM_CH];
    logic signed [23:0] m_r [NUM_CH];
    logic [4:0]         m_g [NUM_CH];
    logic               m_m [NUM_CH];

    audio_mix_seq_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) bus ();

    audio_mix_seq #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [23:0] l, input logic [23:0] r,
                          input logic [4:0] g, input logic m);
        bus.ch_left[i*IN_W +: IN_W]    = l;
        bus.ch_right[i*IN_W +: IN_W]   = r;
        bus.ch_gain[i*GAIN_W +: GAIN_W] = g;
        bus.ch_mute[i]                 = m;
        m_l[i] = l;
        m_r[i] = r;
        m_g[i] = g;
        m_m[i] = m;
    endtask

    task automatic push_exp(input logic [23:0] l, input logic [23:0] r, input logic cl, input logic cr);
        exp_t e;
        e.l = l; e.r = r; e.cl = cl; e.cr = cr; e.id = sample_id;
        sample_id++;
        sb.push_back(e);
    endtask

    function automatic logic [24:0] sat_m(input longint a);
        longint s;
        s = a >>> 4;
        if (s > 64'sd8388607) return {1'b1, 24'h7FFFFF};
        else if (s < -64'sd8388608) return {1'b1, 24'h800000};
        else return {1'b0, s[23:0]};
    endfunction

    // Reference mix of the currently driven channel values.
    task automatic push_model();
        longint al, ar;
        logic [24:0] sl, sr;
        al = 0; ar = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!m_m[i]) begin
                al += longint'(m_l[i]) * longint'({59'd0, m_g[i]});
                ar += longint'(m_r[i]) * longint'({59'd0, m_g[i]});
            end
        end
        sl = sat_m(al);
        sr = sat_m(ar);
        push_exp(sl[23:0], sr[23:0], sl[24], sr[24]);
    endtask

    task automatic strobe();
        bus.next_sample = 1'b1;
        tick();
        bus.next_sample = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                n = k;
                break;
            end
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest queued expectation.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            check("valid_not_back_to_back", {63'd0, prev_valid & bus.out_valid}, 64'd0);
        end
        prev_valid = bus.out_valid;
        if (bus.out_valid === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_valid observed=%0h expected=none", bus.out_left);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("out_left#%0d", e.id),   {40'd0, bus.out_left},  {40'd0, e.l});
                check($sformatf("out_right#%0d", e.id),  {40'd0, bus.out_right}, {40'd0, e.r});
                check($sformatf("clip_left#%0d", e.id),  {63'd0, bus.clip_left},  {63'd0, e.cl});
                check($sformatf("clip_right#%0d", e.id), {63'd0, bus.clip_right}, {63'd0, e.cr});
            end
        end
    end

    initial begin
        int n;
        rst_n           = 1'b0;
        bus.next_sample = 1'b0;
        bus.overrun_clr = 1'b0;
        bus.ch_left     = '0;
        bus.ch_right    = '0;
        bus.ch_gain     = '0;
        bus.ch_mute     = '0;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 24'h0, 24'h0, 5'd0, 1'b0);
        repeat (3) tick();
        check("rst_out_left",  {40'd0, bus.out_left},  64'd0);
        check("rst_out_right", {40'd0, bus.out_right}, 64'd0);
        check("rst_valid",     {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy",      {63'd0, bus.busy},      64'd0);
        check("rst_overrun",   {63'd0, bus.overrun},   64'd0);
        check("rst_clip",      {62'd0, bus.clip_left, bus.clip_right}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Unity gain, ch1-3 muted with non-zero data.
        set_ch(0, 24'h100000, 24'h080000, 5'd16, 1'b0);
        for (int i = 1; i < NUM_CH; i++) set_ch(i, 24'h123456, 24'h654321, 5'd31, 1'b1);
        push_exp(24'h100000, 24'h080000, 1'b0, 1'b0);
        strobe();
        check("busy_after_strobe", {63'd0, bus.busy}, 64'd1);
        wait_valid(n);
        check("latency_unity", 64'(n), 64'd5);
        check("busy_after_valid", {63'd0, bus.busy}, 64'd0);

        // Positive saturation, accepted immediately after SAT.
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 24'h300000, 24'h000010, 5'd16, 1'b0);
        push_exp(24'h7FFFFF, 24'h000040, 1'b1, 1'b0);
        strobe();
        wait_valid(n);
        check("latency_back_to_back", 64'(n), 64'd5);
        // Held between updates.
        tick();
        check("hold_out_left", {40'd0, bus.out_left}, 64'h7FFFFF);
        check("hold_clip_left", {63'd0, bus.clip_left}, 64'd1);

        // Negative saturation.
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 24'hD00000, 24'hFFFFF0, 5'd16, 1'b0);
        push_exp(24'h800000, 24'hFFFFC0, 1'b1, 1'b0);
        strobe();
        wait_valid(n);
        check("latency_negsat", 64'(n), 64'd5);

        // Gain 8 with floor rounding, then gain 31.
        for (int i = 1; i < NUM_CH; i++) set_ch(i, 24'h7FFFFF, 24'h7FFFFF, 5'd31, 1'b1);
        set_ch(0, 24'h000011, 24'hFFFFEF, 5'd8, 1'b0);
        push_exp(24'h000008, 24'hFFFFF7, 1'b0, 1'b0);
        strobe();
        wait_valid(n);
        set_ch(0, 24'h200000, 24'h000000, 5'd31, 1'b0);
        push_exp(24'h3E0000, 24'h000000, 1'b0, 1'b0);
        strobe();
        wait_valid(n);

        // Gain 0 unmuted contributes nothing.
        set_ch(0, 24'h7FFFFF, 24'h800000, 5'd0, 1'b0);
        set_ch(1, 24'h000100, 24'h000200, 5'd16, 1'b0);
        push_exp(24'h000100, 24'h000200, 1'b0, 1'b0);
        strobe();
        wait_valid(n);

        // Overrun: strobe at T and T+2, then clear together with a fresh strobe at T+6.
        push_model();
        strobe();
        tick();
        strobe();
        check("overrun_set", {63'd0, bus.overrun}, 64'd1);
        repeat (3) tick();
        check("overrun_valid_at_T5", {63'd0, bus.out_valid}, 64'd1);
        set_ch(2, 24'h0ABCDE, 24'hF00000, 5'd20, 1'b0);
        push_model();
        bus.overrun_clr = 1'b1;
        strobe();
        bus.overrun_clr = 1'b0;
        check("overrun_cleared", {63'd0, bus.overrun}, 64'd0);
        check("strobe_T6_accepted", {63'd0, bus.busy}, 64'd1);
        // Strobe during busy with clear in the same cycle: set wins.
        bus.overrun_clr = 1'b1;
        strobe();
        bus.overrun_clr = 1'b0;
        check("overrun_set_wins", {63'd0, bus.overrun}, 64'd1);
        wait_valid(n);
        check("latency_after_overrun", 64'(n), 64'd4);
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;

        // Snapshot: change inputs right after the strobe edge.
        set_ch(0, 24'h010000, 24'h020000, 5'd16, 1'b0);
        for (int i = 1; i < NUM_CH; i++) set_ch(i, 24'h0, 24'h0, 5'd0, 1'b1);
        push_exp(24'h010000, 24'h020000, 1'b0, 1'b0);
        strobe();
        set_ch(0, 24'h7F0000, 24'h020000, 5'd31, 1'b0);
        wait_valid(n);

        // Random patterns against the reference mix.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NUM_CH; i++)
                set_ch(i, 24'($urandom), 24'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) == 0));
            push_model();
            strobe();
            wait_valid(n);
            check("latency_random", 64'(n), 64'd5);
        end

        // Reset mid-mix with overrun pending: aborted sample never appears.
        check("pre_reset_nonzero", {63'd0, (bus.out_left != 24'h0) || (bus.out_right != 24'h0)}, 64'd1);
        strobe();
        strobe();
        check("overrun_before_reset", {63'd0, bus.overrun}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_left",  {40'd0, bus.out_left},  64'd0);
        check("midrst_out_right", {40'd0, bus.out_right}, 64'd0);
        check("midrst_busy",      {63'd0, bus.busy},      64'd0);
        check("midrst_overrun",   {63'd0, bus.overrun},   64'd0);
        repeat (8) tick();
        set_ch(0, 24'h000040, 24'hFFFFC0, 5'd16, 1'b0);
        push_exp(24'h000040, 24'hFFFFC0, 1'b0, 1'b0);
        strobe();
        wait_valid(n);
        check("latency_after_reset", 64'(n), 64'd5);

        repeat (3) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
